// File: rtl/uart_rx.sv
// UART receiver for 11-bit frames: start, 8 data bits LSB first, parity, stop.
// Mid-bit sampling via a baud counter; one-cycle data_valid with parity/framing status.
module uart_rx #(
    parameter int CLKS_PER_BIT = 16,
    parameter bit PARITY_ODD   = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_in,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       parity_err,
    output logic       frame_err,
    output logic       rx_busy
);

    localparam int HALF = CLKS_PER_BIT / 2;
    localparam int CW   = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] STOP   = 3'd4;
    localparam logic [2:0] BREAK  = 3'd5;

    logic [1:0]    sync_reg;
    logic          rx_s;
    logic [2:0]    state_reg, state_next;
    logic [CW-1:0] baud_cnt_reg, baud_cnt_next;
    logic [2:0]    bit_cnt_reg, bit_cnt_next;
    logic [7:0]    shreg_reg, shreg_next;
    logic          par_sample_reg, par_sample_next;
    logic [7:0]    data_out_reg, data_out_next;
    logic          data_valid_reg, data_valid_next;
    logic          parity_err_reg, parity_err_next;
    logic          frame_err_reg, frame_err_next;
    logic          baud_last;

    // Two-flop synchroniser; idles high so reset does not look like a start bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_reg <= 2'b11;
        end else begin
            sync_reg <= {sync_reg[0], rx_in};
        end
    end

    assign rx_s      = sync_reg[1];
    assign baud_last = (baud_cnt_reg == BAUD_LAST);

    always_comb begin
        state_next      = state_reg;
        bit_cnt_next    = bit_cnt_reg;
        shreg_next      = shreg_reg;
        par_sample_next = par_sample_reg;
        data_out_next   = data_out_reg;
        parity_err_next = parity_err_reg;
        frame_err_next  = frame_err_reg;
        data_valid_next = 1'b0;

        case (state_reg)
            IDLE: begin
                if (!rx_s) state_next = START;
            end
            START: begin
                // Ending START at the half-bit point puts later samples mid-bit.
                if (baud_cnt_reg == HALF_LAST) begin
                    state_next   = rx_s ? IDLE : DATA;
                    bit_cnt_next = 3'd0;
                end
            end
            DATA: begin
                if (baud_last) begin
                    shreg_next   = {rx_s, shreg_reg[7:1]};
                    bit_cnt_next = bit_cnt_reg + 3'd1;
                    if (bit_cnt_reg == 3'd7) state_next = PARITY;
                end
            end
            PARITY: begin
                if (baud_last) begin
                    par_sample_next = rx_s;
                    state_next      = STOP;
                end
            end
            STOP: begin
                if (baud_last) begin
                    data_out_next   = shreg_reg;
                    parity_err_next = ((^shreg_reg) ^ par_sample_reg) != PARITY_ODD;
                    frame_err_next  = ~rx_s;
                    data_valid_next = 1'b1;
                    state_next      = rx_s ? IDLE : BREAK;
                end
            end
            BREAK: begin
                // A line held low must return high before a new start is accepted.
                if (rx_s) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase

        if ((state_next != state_reg) || baud_last ||
            (state_reg == IDLE) || (state_reg == BREAK)) begin
            baud_cnt_next = '0;
        end else begin
            baud_cnt_next = baud_cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= IDLE;
            baud_cnt_reg   <= '0;
            bit_cnt_reg    <= 3'd0;
            shreg_reg      <= 8'h00;
            par_sample_reg <= 1'b0;
            data_out_reg   <= 8'h00;
            data_valid_reg <= 1'b0;
            parity_err_reg <= 1'b0;
            frame_err_reg  <= 1'b0;
        end else begin
            state_reg      <= state_next;
            baud_cnt_reg   <= baud_cnt_next;
            bit_cnt_reg    <= bit_cnt_next;
            shreg_reg      <= shreg_next;
            par_sample_reg <= par_sample_next;
            data_out_reg   <= data_out_next;
            data_valid_reg <= data_valid_next;
            parity_err_reg <= parity_err_next;
            frame_err_reg  <= frame_err_next;
        end
    end

    assign data_out   = data_out_reg;
    assign data_valid = data_valid_reg;
    assign parity_err = parity_err_reg;
    assign frame_err  = frame_err_reg;
    assign rx_busy    = (state_reg != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: frames are driven serially, expected results queued
// at send time and popped whenever the receiver pulses data_valid.
module tb_uart_rx;

    localparam int CPB = 16;

    typedef struct packed {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_in = 1'b1;
    logic [7:0] data_out;
    logic       data_valid;
    logic       parity_err;
    logic       frame_err;
    logic       rx_busy;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   pulses = 0;
    int   pulse_cyc[$];
    logic prev_valid = 1'b0;

    uart_rx #(.CLKS_PER_BIT(CPB), .PARITY_ODD(1'b0)) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_in     (rx_in),
        .data_out  (data_out),
        .data_valid(data_valid),
        .parity_err(parity_err),
        .frame_err (frame_err),
        .rx_busy   (rx_busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        tests++;
        assert (obs === expv)
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // One clock; outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        cyc++;
        if (data_valid === 1'b1) begin
            check("valid_one_cycle", {15'd0, prev_valid}, 16'd0);
            check("valid_expected", {15'd0, exp_q.size() != 0}, 16'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("data_out", {8'd0, data_out}, {8'd0, e.data});
                check("parity_err", {15'd0, parity_err}, {15'd0, e.perr});
                check("frame_err", {15'd0, frame_err}, {15'd0, e.ferr});
                $display("[TB] rx frame data=%02h perr=%0b ferr=%0b at cycle %0d",
                         data_out, parity_err, frame_err, cyc);
            end
            pulses++;
            pulse_cyc.push_back(cyc);
        end
        prev_valid = data_valid;
    endtask

    task automatic send_bit(input logic b);
        rx_in = b;
        repeat (CPB) tick();
    endtask

    task automatic idle_bits(input int n);
        rx_in = 1'b1;
        repeat (n * CPB) tick();
    endtask

    // Sends start, data LSB first, parity and stop; queues the expected result.
    task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
        exp_t e;
        e.data = d;
        e.perr = (^d) ^ par;
        e.ferr = ~stop;
        exp_q.push_back(e);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(par);
        send_bit(stop);
    endtask

    task automatic check_idle_outputs(input string tag);
        check(tag, {5'd0, data_out, data_valid, parity_err, frame_err, rx_busy}, 16'd0);
    endtask

    initial begin
        int base;

        // Reset state.
        #1;
        check_idle_outputs("reset_outputs");
        repeat (3) tick();
        check_idle_outputs("reset_held");
        rst = 1'b0;
        idle_bits(2);
        check_idle_outputs("after_reset");

        // Basic frame.
        send_frame(8'hA5, 1'b0, 1'b1);
        idle_bits(2);
        check("pulses_a5", 16'(pulses), 16'd1);

        // Start-bit glitch rejected.
        rx_in = 1'b0;
        repeat (4) tick();
        rx_in = 1'b1;
        repeat (3) tick();
        check("busy_in_glitch", {15'd0, rx_busy}, 16'd1);
        idle_bits(2);
        check("busy_after_glitch", {15'd0, rx_busy}, 16'd0);
        check("pulses_glitch", 16'(pulses), 16'd1);
        check("data_kept_glitch", {8'd0, data_out}, 16'h00A5);
        check("flags_kept_glitch", {14'd0, parity_err, frame_err}, 16'd0);

        // Parity error then clean frame.
        send_frame(8'h3C, 1'b1, 1'b1);
        idle_bits(1);
        send_frame(8'h3C, 1'b0, 1'b1);
        idle_bits(1);
        check("pulses_3c", 16'(pulses), 16'd3);

        // Framing error with line held low (break).
        send_frame(8'h81, 1'b0, 1'b0);
        rx_in = 1'b0;
        repeat (40 * CPB) tick();
        check("busy_in_break", {15'd0, rx_busy}, 16'd1);
        check("pulses_break", 16'(pulses), 16'd4);
        idle_bits(2);
        check("busy_after_break", {15'd0, rx_busy}, 16'd0);
        send_frame(8'h55, 1'b0, 1'b1);
        idle_bits(1);
        check("pulses_55", 16'(pulses), 16'd5);

        // Back-to-back frames, no idle gap.
        base = pulses;
        send_frame(8'h00, 1'b0, 1'b1);
        send_frame(8'hFF, 1'b0, 1'b1);
        idle_bits(1);
        check("pulses_b2b", 16'(pulses), 16'(base + 2));
        if (pulse_cyc.size() >= base + 2)
            check("b2b_spacing", 16'(pulse_cyc[base + 1] - pulse_cyc[base]), 16'd176);

        // Reset during bit 4 of 0x5A: aborted frame never reported.
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(((8'h5A >> i) & 8'h01) != 0);
        rx_in = 1'b1;
        repeat (CPB / 2) tick();
        check("busy_before_rst", {15'd0, rx_busy}, 16'd1);
        rst = 1'b1;
        #1;
        check_idle_outputs("async_reset");
        repeat (3) tick();
        check_idle_outputs("during_reset");
        rst = 1'b0;
        tick();
        check_idle_outputs("after_mid_reset");
        idle_bits(2);
        check("pulses_after_rst", 16'(pulses), 16'(base + 2));
        send_frame(8'h12, 1'b0, 1'b1);
        idle_bits(2);
        check("pulses_12", 16'(pulses), 16'(base + 3));
        check("queue_empty", 16'(exp_q.size()), 16'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Hard bound on run time in case stimulus stalls.
    initial begin
        #2000000;
        $display("[TB] FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
